// File: rtl/date_to_posix_time.sv
// date_to_posix_time: converts a local calendar date/time into UTC posix
// seconds. Days are accumulated iteratively, one year per cycle and then one
// month per cycle, so latency grows with the distance from 1970-01-01.
module date_to_posix_time #(
    parameter int GMT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [11:0] year_i,
    input  logic [3:0]  month_i,
    input  logic [4:0]  day_i,
    input  logic [4:0]  hour_i,
    input  logic [5:0]  min_i,
    input  logic [5:0]  sec_i,
    output logic [31:0] posix_time_o,
    output logic        posix_time_en_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        IDLE, CHECK, YEARS, MONTHS, CALC, DONE
    } state_t;

    localparam logic [33:0] OFFSET = 34'(GMT * 3600);

    state_t      r_state, w_next;
    logic [11:0] r_year, r_cur_year;
    logic [3:0]  r_month, r_cur_mon;
    logic [4:0]  r_day, r_hour;
    logic [5:0]  r_min, r_sec;
    logic [15:0] r_acc;
    logic [31:0] r_result;
    logic        r_fail;

    logic        w_leap, w_cur_leap, w_ok;
    logic [33:0] w_days, w_local;

    function automatic logic [15:0] days_in_month(input logic [3:0] m, input logic leap);
        case (m)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: days_in_month = 16'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                    days_in_month = 16'd30;
            4'd2:    days_in_month = leap ? 16'd29 : 16'd28;
            default: days_in_month = 16'd0;
        endcase
    endfunction

    assign w_leap     = (r_year[1:0] == 2'b00);
    assign w_cur_leap = (r_cur_year[1:0] == 2'b00);

    // Range validation of the latched fields, evaluated in CHECK
    always_comb begin
        w_ok = 1'b1;
        if (r_year < 12'd1970 || r_year > 12'd2099) w_ok = 1'b0;
        if (r_month < 4'd1 || r_month > 4'd12)      w_ok = 1'b0;
        if (r_day == 5'd0 || 16'(r_day) > days_in_month(r_month, w_leap)) w_ok = 1'b0;
        if (r_hour > 5'd23) w_ok = 1'b0;
        if (r_min > 6'd59)  w_ok = 1'b0;
        if (r_sec > 6'd59)  w_ok = 1'b0;
    end

    assign w_days  = 34'(r_acc) + 34'(r_day) - 34'd1;
    assign w_local = w_days * 34'd86400 + 34'(r_hour) * 34'd3600
                   + 34'(r_min) * 34'd60 + 34'(r_sec);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (start_i) w_next = CHECK;
            CHECK: begin
                if (!w_ok)                   w_next = DONE;
                else if (r_year != 12'd1970) w_next = YEARS;
                else if (r_month != 4'd1)    w_next = MONTHS;
                else                         w_next = CALC;
            end
            YEARS:  if (r_cur_year == r_year - 12'd1)
                        w_next = (r_month == 4'd1) ? CALC : MONTHS;
            MONTHS: if (r_cur_mon == r_month - 4'd1) w_next = CALC;
            CALC:   w_next = DONE;
            DONE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign busy_o = (r_state != IDLE);

    // Datapath: field latch, day accumulation, final arithmetic and strobes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_year <= '0; r_month <= '0; r_day <= '0;
            r_hour <= '0; r_min <= '0; r_sec <= '0;
            r_cur_year <= '0; r_cur_mon <= '0;
            r_acc <= '0; r_result <= '0; r_fail <= 1'b0;
            posix_time_o <= '0; posix_time_en_o <= 1'b0; err_o <= 1'b0;
        end else begin
            posix_time_en_o <= 1'b0;
            err_o           <= 1'b0;
            case (r_state)
                IDLE: if (start_i) begin
                    r_year <= year_i; r_month <= month_i; r_day <= day_i;
                    r_hour <= hour_i; r_min <= min_i; r_sec <= sec_i;
                    r_acc <= '0; r_cur_year <= 12'd1970; r_cur_mon <= 4'd1;
                    r_fail <= 1'b0;
                end
                CHECK: r_fail <= !w_ok;
                YEARS: begin
                    r_acc      <= r_acc + (w_cur_leap ? 16'd366 : 16'd365);
                    r_cur_year <= r_cur_year + 12'd1;
                end
                MONTHS: begin
                    r_acc     <= r_acc + days_in_month(r_cur_mon, w_leap);
                    r_cur_mon <= r_cur_mon + 4'd1;
                end
                CALC: begin
                    if (w_local < OFFSET) r_fail <= 1'b1;
                    else                  r_result <= 32'(w_local - OFFSET);
                end
                DONE: begin
                    if (r_fail) err_o <= 1'b1;
                    else begin
                        posix_time_o    <= r_result;
                        posix_time_en_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_date_to_posix_time.sv
// Scoreboard bench for date_to_posix_time: requests push the expected strobe
// kind, value and arrival cycle; an independent monitor pops and compares.
module tb_date_to_posix_time;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] year = '0;
    logic [3:0]  month = '0;
    logic [4:0]  day = '0, hour = '0;
    logic [5:0]  mins = '0, secs = '0;
    logic [31:0] posix;
    logic        en, busy, err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;

    typedef struct {
        bit          is_err;
        logic [31:0] val;
        int          at;
    } exp_t;
    exp_t sb[$];

    date_to_posix_time #(.GMT(3)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .year_i(year), .month_i(month), .day_i(day),
        .hour_i(hour), .min_i(mins), .sec_i(secs),
        .posix_time_o(posix), .posix_time_en_o(en),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every strobe against the head of the scoreboard
    always @(negedge clk) begin
        if (en || err) begin
            exp_t e;
            pulses++;
            checks++;
            if (en && err) begin
                errors++;
                $display("FAIL both_strobes: en=%0d err=%0d required one only", en, err);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: en=%0d err=%0d posix=%0d at cyc %0d, none required",
                         en, err, posix, cyc);
            end else begin
                e = sb.pop_front();
                if (err !== e.is_err || cyc != e.at || (!e.is_err && posix !== e.val)) begin
                    errors++;
                    $display("FAIL strobe: got err=%0d posix=%0d cyc=%0d, required err=%0d posix=%0d cyc=%0d",
                             err, posix, cyc, e.is_err, e.val, e.at);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    // Issue one request (called on a negedge) and wait for its strobe.
    // repulse>0 re-pulses start_i with different fields that many cycles in.
    task automatic req(input int y, input int mo, input int d, input int h, input int mi,
                       input int s, input bit is_err, input logic [31:0] val, input int lat,
                       input logic [31:0] keep, input int repulse);
        exp_t e;
        int   bcnt = 0;
        bit   seen = 0;
        year = 12'(y); month = 4'(mo); day = 5'(d); hour = 5'(h); mins = 6'(mi); secs = 6'(s);
        start = 1'b1;
        e.is_err = is_err; e.val = val; e.at = cyc + 1 + lat;
        sb.push_back(e);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (repulse > 0 && i + 1 == repulse) begin
                year = 12'd1970; month = 4'd1; day = 5'd1; hour = 5'd5; mins = '0; secs = '0;
                start = 1'b1;
            end
            if (busy) bcnt++;
            if (en || err) begin seen = 1; break; end
        end
        start = 1'b0;
        check("strobe_seen", 32'(seen), 32'd1);
        check("busy_cycles", 32'(bcnt), 32'(lat));
        check("posix_hold", posix, is_err ? keep : val);
    endtask

    initial begin
        #2;
        check("rst_posix", posix, 32'd0);
        check("rst_en", 32'(en), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        req(1970, 1, 1, 3, 0, 0, 0, 32'd0, 3, 0, 0);
        req(2000, 3, 1, 3, 0, 0, 0, 32'd951868800, 35, 0, 0);
        req(1970, 3, 1, 0, 0, 0, 0, 32'd5086800, 5, 0, 0);
        req(1972, 12, 31, 3, 0, 0, 0, 32'd94608000, 16, 0, 0);
        req(2024, 2, 29, 12, 0, 0, 0, 32'd1709197200, 58, 0, 0);
        req(2023, 2, 29, 12, 0, 0, 1, 0, 2, 32'd1709197200, 0);
        req(1970, 1, 1, 1, 0, 0, 1, 0, 3, 32'd1709197200, 0);
        req(1969, 6, 1, 0, 0, 0, 1, 0, 2, 32'd1709197200, 0);
        req(2100, 1, 1, 0, 0, 0, 1, 0, 2, 32'd1709197200, 0);
        req(2001, 13, 1, 0, 0, 0, 1, 0, 2, 32'd1709197200, 0);
        req(2001, 4, 0, 0, 0, 0, 1, 0, 2, 32'd1709197200, 0);
        req(2001, 4, 31, 0, 0, 0, 1, 0, 2, 32'd1709197200, 0);
        req(2001, 4, 30, 24, 0, 0, 1, 0, 2, 32'd1709197200, 0);
        req(2001, 4, 30, 23, 60, 0, 1, 0, 2, 32'd1709197200, 0);
        req(2001, 4, 30, 23, 59, 60, 1, 0, 2, 32'd1709197200, 0);
        req(2099, 12, 31, 23, 59, 59, 0, 32'd4102433999, 143, 0, 5);

        // Second run aborted by reset during YEARS
        @(negedge clk);
        year = 12'd2099; month = 4'd12; day = 5'd31; hour = 5'd23; mins = 6'd59; secs = 6'd59;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("midrun_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_posix", posix, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (160) @(negedge clk);
        check("abort_no_strobe", 32'(pulses), 32'd0);
        check("abort_busy_after", 32'(busy), 32'd0);
        check("abort_posix_after", posix, 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
